// File: rtl/fetch_ctrl.sv
// fetch_ctrl: front-end sequencer for the 5-stage core.
// Drives the PC generator (stall_pc / npc_mux_sel) and the IF/ID register
// (stall_if_id / flush_if_id), and paces fetch with an imem req/ack handshake.
// A watchdog traps a memory that never acks. Two saturating counters record
// stall and flush activity while fetching.
module fetch_ctrl #(
  parameter int unsigned IMEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        beq_bne_taken_id,
  input  logic        jr_id,
  input  logic        jal_j_id,
  input  logic        load_use_hazard_id,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        stall_pc,
  output logic [2:0]  npc_mux_sel,
  output logic        stall_if_id,
  output logic        flush_if_id,
  output logic        fetch_err,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    ERR   = 2'd2
  } state_t;

  localparam logic [15:0] TIMEOUT = 16'(IMEM_TIMEOUT);

  state_t      state;
  logic [15:0] wd_cnt;
  logic [15:0] wd_inc;
  logic        redirect;

  assign wd_inc   = wd_cnt + 16'd1;
  assign redirect = beq_bne_taken_id | jr_id | jal_j_id;

  // Pipeline control outputs, decoded from the current state and this cycle's inputs.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves it unassigned, which would otherwise infer a latch.
    imem_req    = 1'b0;
    stall_pc    = 1'b1;
    npc_mux_sel = 3'b000;
    stall_if_id = 1'b0;
    flush_if_id = 1'b1;
    unique case (state)
      BOOT: begin
        // Hold PC 0 and push a bubble into ID until fetching starts.
      end
      FETCH: begin
        imem_req    = 1'b1;
        flush_if_id = 1'b0;
        if (!imem_ack || load_use_hazard_id) begin
          // Memory wait or load-use: freeze PC and IF/ID, refetch same PC.
          stall_pc    = 1'b1;
          stall_if_id = 1'b1;
        end else if (redirect) begin
          // Squash the sequential fetch and steer the PC to the target.
          stall_pc    = 1'b0;
          flush_if_id = 1'b1;
          if (beq_bne_taken_id)  npc_mux_sel = 3'b100;
          else if (jr_id)        npc_mux_sel = 3'b010;
          else                   npc_mux_sel = 3'b001;
        end else begin
          stall_pc = 1'b0;
        end
      end
      ERR: begin
        stall_if_id = 1'b1;
        flush_if_id = 1'b0;
      end
      default: begin
        stall_if_id = 1'b1;
        flush_if_id = 1'b0;
      end
    endcase
  end

  // Control FSM with the fetch watchdog and the sticky error flag.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      state     <= BOOT;
      wd_cnt    <= 16'd0;
      fetch_err <= 1'b0;
    end else begin
      unique case (state)
        BOOT: begin
          state  <= FETCH;
          wd_cnt <= 16'd0;
        end
        FETCH: begin
          if (imem_ack) begin
            wd_cnt <= 16'd0;
          end else begin
            wd_cnt <= wd_inc;
            if (wd_inc == TIMEOUT) begin
              state     <= ERR;
              fetch_err <= 1'b1;
            end
          end
        end
        ERR: begin
          // Only rst leaves ERR.
        end
        default: state <= ERR;
      endcase
    end
  end

  // Saturating event counters; they advance only while fetching.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else if (state == FETCH) begin
      if (stall_pc && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
      if (flush_if_id && (flush_cnt != 32'hFFFF_FFFF))
        flush_cnt <= flush_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a behavioural reference model and a
// scoreboard queue of expected outputs per cycle.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        beq_bne_taken_id = 1'b0;
  logic        jr_id = 1'b0;
  logic        jal_j_id = 1'b0;
  logic        load_use_hazard_id = 1'b0;
  logic        imem_ack = 1'b0;
  logic        imem_req;
  logic        stall_pc;
  logic [2:0]  npc_mux_sel;
  logic        stall_if_id;
  logic        flush_if_id;
  logic        fetch_err;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  localparam int TIMEOUT = 4;

  always #5 clk = ~clk;

  fetch_ctrl #(.IMEM_TIMEOUT(TIMEOUT)) dut (
    .clk                (clk),
    .rst                (rst),
    .beq_bne_taken_id   (beq_bne_taken_id),
    .jr_id              (jr_id),
    .jal_j_id           (jal_j_id),
    .load_use_hazard_id (load_use_hazard_id),
    .imem_req           (imem_req),
    .imem_ack           (imem_ack),
    .stall_pc           (stall_pc),
    .npc_mux_sel        (npc_mux_sel),
    .stall_if_id        (stall_if_id),
    .flush_if_id        (flush_if_id),
    .fetch_err          (fetch_err),
    .stall_cnt          (stall_cnt),
    .flush_cnt          (flush_cnt)
  );

  typedef enum {M_BOOT, M_FETCH, M_ERR} mstate_t;

  typedef struct {
    logic        req;
    logic        stall;
    logic [2:0]  sel;
    logic        sid;
    logic        fl;
    logic        chk_fl;
    logic        err;
    logic [31:0] scnt;
    logic [31:0] fcnt;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;

  mstate_t     m_state;
  int          m_wd;
  logic        m_err;
  logic [31:0] m_scnt;
  logic [31:0] m_fcnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = M_BOOT;
    m_wd    = 0;
    m_err   = 1'b0;
    m_scnt  = 32'd0;
    m_fcnt  = 32'd0;
  endtask

  // One clock cycle: drive inputs, queue the model's expectation, compare mid-cycle.
  task automatic step(input logic a, input logic br, input logic j, input logic jl, input logic lu);
    exp_t e;
    exp_t got;
    imem_ack = a; beq_bne_taken_id = br; jr_id = j; jal_j_id = jl; load_use_hazard_id = lu;
    e.req = 1'b0; e.stall = 1'b1; e.sel = 3'b000; e.sid = 1'b0; e.fl = 1'b1;
    case (m_state)
      M_BOOT: ;
      M_ERR: begin e.sid = 1'b1; e.fl = 1'b0; end
      default: begin
        e.req = 1'b1;
        if (!a || lu) begin
          e.sid = 1'b1; e.fl = 1'b0;
        end else if (br || j || jl) begin
          e.stall = 1'b0; e.fl = 1'b1;
          e.sel = br ? 3'b100 : (j ? 3'b010 : 3'b001);
        end else begin
          e.stall = 1'b0; e.fl = 1'b0;
        end
      end
    endcase
    // flush_if_id is don't-care while IF/ID is frozen during fetch.
    e.chk_fl = !(m_state == M_FETCH && e.sid);
    e.err  = m_err;
    e.scnt = m_scnt;
    e.fcnt = m_fcnt;
    sb.push_back(e);

    @(negedge clk);
    got = sb.pop_front();
    check("imem_req", {31'd0, imem_req}, {31'd0, got.req});
    check("stall_pc", {31'd0, stall_pc}, {31'd0, got.stall});
    check("npc_mux_sel", {29'd0, npc_mux_sel}, {29'd0, got.sel});
    check("stall_if_id", {31'd0, stall_if_id}, {31'd0, got.sid});
    if (got.chk_fl) check("flush_if_id", {31'd0, flush_if_id}, {31'd0, got.fl});
    check("fetch_err", {31'd0, fetch_err}, {31'd0, got.err});
    check("stall_cnt", stall_cnt, got.scnt);
    check("flush_cnt", flush_cnt, got.fcnt);

    // Advance the reference model across the coming edge.
    if (m_state == M_FETCH) begin
      if (got.stall && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 32'd1;
      if (got.fl && m_fcnt != 32'hFFFF_FFFF)    m_fcnt = m_fcnt + 32'd1;
    end
    case (m_state)
      M_BOOT: begin m_state = M_FETCH; m_wd = 0; end
      M_FETCH: begin
        if (a) m_wd = 0;
        else begin
          m_wd++;
          if (m_wd == TIMEOUT) begin m_state = M_ERR; m_err = 1'b1; end
        end
      end
      default: ;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [31:0] base;
    model_reset();
    do_reset();

    // Zero-wait memory: BOOT, then one fetch per cycle.
    step(1, 0, 0, 0, 0);
    repeat (6) step(1, 0, 0, 0, 0);
    check("idle_stall_cnt", stall_cnt, 32'd0);
    check("idle_flush_cnt", flush_cnt, 32'd0);

    // Ack every third cycle over 30 cycles: 20 stall cycles.
    base = m_scnt;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
    end
    check("stall_cnt_30cyc", stall_cnt - base, 32'd20);

    // Branch and j together: branch wins.
    base = m_fcnt;
    step(1, 1, 0, 1, 0);
    check("flush_cnt_inc", flush_cnt - base, 32'd1);

    // Load-use with jr: stall first, then jr redirect.
    step(1, 0, 1, 0, 1);
    step(1, 0, 1, 0, 0);

    // Remaining redirect encodings and a waited redirect.
    step(1, 0, 0, 1, 0);
    step(1, 0, 1, 1, 0);
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    // Preload stall_cnt near saturation, then starve the memory into ERR.
    force dut.stall_cnt = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cnt;
    m_scnt = 32'hFFFF_FFFD;
    repeat (TIMEOUT) step(0, 0, 0, 0, 0);
    check("stall_cnt_sat", stall_cnt, 32'hFFFF_FFFF);
    check("enter_err", {31'd0, fetch_err}, 32'd1);
    repeat (10) step(0, 1, 1, 1, 1);
    check("err_stall_cnt_frozen", stall_cnt, 32'hFFFF_FFFF);

    // Reset out of ERR returns to BOOT with fetch_err cleared.
    do_reset();
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: observed no completion, expected completion");
    $fatal(1, "time limit");
  end

endmodule
